// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//   Executes LB/LH/LW/LBU/LHU. It forms the effective address from base_addr
//   and imm, rejects illegal func3 and misaligned accesses, and issues a
//   word-aligned read over a req/gnt/rvalid handshake. The selected byte, half
//   or word is sign- or zero-extended and returned with a one-cycle done pulse.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             load request, sampled only while idle
//   base_addr, imm    rs1 value and sign-extended offset
//   func3             load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//   busy              high whenever a load is in progress
//   done              one-cycle pulse; load_data/fault_code valid with it
//   load_data         extended result (0 on any fault)
//   fault_code        00 ok, 01 misaligned, 10 illegal func3, 11 timeout
//   mem_req/mem_addr  word-aligned read request toward data memory
//   mem_gnt           request accepted
//   mem_rvalid/rdata  read response
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255  // legal range 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] imm,
  input  logic [2:0]  func3,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_ILL = 2'b10;
  localparam logic [1:0] F_TMO = 2'b11;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  lane_q,  lane_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [31:0] data_q,  data_d;
  logic [1:0]  fault_q, fault_d;

  logic [31:0] ea;
  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted;

  // Address arithmetic wraps modulo 2^32; there is no overflow reporting.
  assign ea = base_addr + imm;

  assign illegal    = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
  // func3[1:0]==01 covers both LH and LHU.
  assign misaligned = ((func3[1:0] == 2'b01) && ea[0]) ||
                      ((func3 == 3'b010) && (ea[1:0] != 2'b00));

  // Lane selection works on the latched offset so that input changes while
  // busy cannot disturb the result.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
  end

  assign half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    extracted = mem_rdata;
    case (func3_q)
      3'b000:  extracted = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  extracted = {24'd0, byte_sel};
      3'b001:  extracted = {{16{half_sel[15]}}, half_sel};
      3'b101:  extracted = {16'd0, half_sel};
      default: extracted = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    func3_d = func3_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = {ea[31:2], 2'b00};
          func3_d = func3;
          lane_d  = ea[1:0];
          cnt_d   = '0;
          // Illegal func3 is checked before alignment so it takes priority.
          if (illegal) begin
            fault_d = F_ILL;
            data_d  = '0;
            state_d = S_RESP;
          end else if (misaligned) begin
            fault_d = F_MIS;
            data_d  = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Data arriving on the limit cycle still completes normally.
        if (mem_rvalid) begin
          data_d  = extracted;
          fault_d = F_OK;
          state_d = S_RESP;
        end else if (cnt_q + 16'd1 == LIMIT) begin
          data_d  = '0;
          fault_d = F_TMO;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      func3_q <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fault_q <= F_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      func3_q <= func3_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_RESP);
  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = addr_q;
  assign load_data  = data_q;
  assign fault_code = fault_q;

endmodule

// File: tb/tb_load_unit.sv
`timescale 1ns/1ps
module tb_load_unit;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] imm;
  logic [2:0]  func3;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  fault_code;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .imm        (imm),
    .func3      (func3),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .fault_code (fault_code),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          gd;      // cycles mem_gnt is held low in REQ
    int          rd;      // WAIT cycles before rvalid
    bit          no_rv;   // never return data (timeout)
    bit          spam;    // keep start high while busy and in RESP
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
    int unsigned done_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_data"},  load_data, mon_e.data);
        check({mon_e.name, "_fault"}, {30'd0, fault_code}, {30'd0, mon_e.fault});
        check({mon_e.name, "_cycle"}, cyc, mon_e.done_cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] b, input logic [31:0] i, input logic [2:0] f,
                              input logic [31:0] rdata, input int gd, input int rd,
                              input bit no_rv, input bit spam, input logic [31:0] ea_w,
                              input logic [31:0] d, input logic [1:0] flt);
    vec_t v;
    v.base = b; v.imm = i; v.f3 = f; v.rdata = rdata; v.gd = gd; v.rd = rd;
    v.no_rv = no_rv; v.spam = spam; v.exp_addr = ea_w; v.exp_data = d; v.exp_fault = flt;
    return v;
  endfunction

  task automatic run_load(input vec_t v, input string name);
    exp_t e;
    int   lat;
    int   guard;
    bit   faulted;
    faulted = (v.exp_fault == 2'b01) || (v.exp_fault == 2'b10);
    if (faulted)      lat = 1;
    else if (v.no_rv) lat = 2 + v.gd + int'(T);
    else              lat = 3 + v.gd + v.rd;
    e.data = v.exp_data; e.fault = v.exp_fault; e.done_cyc = cyc + lat; e.name = name;
    sb.push_back(e);

    start = 1'b1; base_addr = v.base; imm = v.imm; func3 = v.f3;
    tick;
    // Scramble the operands: they were latched on the start edge.
    start = v.spam && !faulted; base_addr = $urandom; imm = $urandom; func3 = 3'($urandom);
    if (faulted) begin
      @(negedge clk);
      check({name, "_no_req"}, {31'd0, mem_req}, 32'd0);
    end else begin
      for (int i = 0; i < v.gd; i++) begin
        @(negedge clk);
        check({name, "_stall_req"},  {31'd0, mem_req}, 32'd1);
        check({name, "_stall_addr"}, mem_addr, v.exp_addr);
        tick;
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      check({name, "_req"},  {31'd0, mem_req}, 32'd1);
      check({name, "_addr"}, mem_addr, v.exp_addr);
      tick;
      mem_gnt = 1'b0;
      if (v.no_rv) begin
        for (int i = 0; i < int'(T); i++) begin
          @(negedge clk);
          check({name, "_wait_req"}, {31'd0, mem_req}, 32'd0);
          tick;
        end
      end else begin
        for (int i = 0; i < v.rd; i++) tick;
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        tick;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      // Now in the RESP cycle; a start held here must be ignored.
      tick;
      start = 1'b0;
    end
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick;
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done, expected done within budget", name);
      sb.delete();
    end
    @(negedge clk);
    check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
    check({name, "_hold_data"},  load_data, v.exp_data);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vecs[12];

  initial begin
    //            base          imm           f3      rdata         gd rd nrv spm addr          data          fault
    vecs[0]  = mk(32'h0000_1000, 32'd3,        3'b000, 32'h80FF_1234, 0, 0, 0, 0, 32'h0000_1000, 32'hFFFF_FF80, 2'b00);
    vecs[1]  = mk(32'h0000_1000, 32'd1,        3'b100, 32'h80FF_1234, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_0012, 2'b00);
    vecs[2]  = mk(32'h0000_1000, 32'd2,        3'b101, 32'h80FF_1234, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_80FF, 2'b00);
    vecs[3]  = mk(32'h0000_1000, 32'd2,        3'b001, 32'h80FF_1234, 0, 0, 0, 0, 32'h0000_1000, 32'hFFFF_80FF, 2'b00);
    vecs[4]  = mk(32'h0000_1000, 32'd2,        3'b010, 32'h80FF_1234, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_0000, 2'b01);
    vecs[5]  = mk(32'h0000_1000, 32'd1,        3'b011, 32'h80FF_1234, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_0000, 2'b10);
    vecs[6]  = mk(32'h0000_1000, 32'd0,        3'b101, 32'h1234_F00D, 2, 1, 0, 0, 32'h0000_1000, 32'h0000_F00D, 2'b00);
    vecs[7]  = mk(32'h0000_1000, 32'd1,        3'b001, 32'h1234_F00D, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_0000, 2'b01);
    vecs[8]  = mk(32'h0000_1000, 32'd3,        3'b111, 32'h1234_F00D, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_0000, 2'b10);
    vecs[9]  = mk(32'hFFFF_FFFC, 32'd8,        3'b010, 32'hDEAD_BEEF, 5, 0, 0, 1, 32'h0000_0004, 32'hDEAD_BEEF, 2'b00);
    vecs[10] = mk(32'h0000_2000, 32'd0,        3'b010, 32'hAAAA_5555, 1, 0, 1, 0, 32'h0000_2000, 32'h0000_0000, 2'b11);
    vecs[11] = mk(32'h0000_2000, 32'd0,        3'b010, 32'h1234_5678, 0, 3, 0, 0, 32'h0000_2000, 32'h1234_5678, 2'b00);

    rst = 1'b1; start = 1'b0; base_addr = '0; imm = '0; func3 = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_data",  load_data, 32'd0);
    check("rst_fault", {30'd0, fault_code}, 32'd0);
    tick; tick;
    rst = 1'b0;
    tick;

    for (int i = 0; i < 12; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Reset while in WAIT: outputs clear at once and a late rvalid is ignored.
    start = 1'b1; base_addr = 32'h0000_3000; imm = 32'd0; func3 = 3'b010;
    tick;
    start = 1'b0; mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    tick;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_req",   {31'd0, mem_req}, 32'd0);
    check("mid_rst_addr",  mem_addr, 32'd0);
    check("mid_rst_data",  load_data, 32'd0);
    check("mid_rst_fault", {30'd0, fault_code}, 32'd0);
    tick;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      tick;
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;

    // Recovery: negative offset, lane 0 signed byte.
    run_load(mk(32'h0000_1010, 32'hFFFF_FFF0, 3'b000, 32'h0000_00A5, 0, 0, 0, 0,
                32'h0000_1000, 32'hFFFF_FFA5, 2'b00), "post_rst_lb");

    tick; tick;
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
